tristate_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared tristate bus built from bufif/notif-style drivers, the same structure as the team's buffered multiplexers and tristate gates.
- Grants the bus to one of N requesters and produces one-hot, registered driver enables.
- Inserts a guaranteed all-drivers-off turnaround gap between owners, so two drivers never fight on the net.
- Bounds each ownership with a hold timeout.

---
 rtl/tristate_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter and sequencer for a shared tristate bus.
// Grants one requester at a time and drives one-hot, registered driver enables.
// A fixed all-off turnaround gap separates consecutive owners, so two drivers
// never fight on the net. Each ownership is bounded by a hold timeout.
module tristate_bus_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         drv_en,
    output logic                 bus_busy,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 timeout
);

    localparam int IDW = $clog2(N);
    localparam int HW  = $clog2(HOLD_MAX + 1);
    localparam int TW  = $clog2(TURN + 1);

    localparam logic [HW-1:0]  HOLD_LIM = HW'(HOLD_MAX);
    localparam logic [TW-1:0]  TURN_LIM = TW'(TURN);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
    localparam logic [IDW:0]   N_EXT    = (IDW + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q,   gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [HW-1:0]  hold_q,  hold_d;
    logic [TW-1:0]  turn_q,  turn_d;
    logic           tout_q,  tout_d;

    logic           win_vld;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   cand;

    logic           own_done;
    logic           own_req;
    logic           hold_hit;
    logic           release_now;

    // One-hot vector with only bit idx set.
    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first requesting index scanning upward from ptr+1,
    // wrapping, so the previous owner is considered last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!win_vld && req[cand[IDW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDW-1:0];
            end
        end
    end

    // Release qualifiers for the current owner; other requesters' bits are ignored.
    always_comb begin
        own_done    = done[owner_q];
        own_req     = req[owner_q];
        hold_hit    = (hold_q == HOLD_LIM);
        release_now = own_done || !own_req || hold_hit;
    end

    // Next-state and registered-output logic for the IDLE/DRIVE/TURN sequencer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        tout_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_DRIVE;
                    gnt_d   = onehot(win_idx);
                    owner_d = win_idx;
                    ptr_d   = win_idx;
                    hold_d  = HW'(1);
                    turn_d  = '0;
                end
            end

            S_DRIVE: begin
                if (release_now) begin
                    state_d = S_TURN;
                    gnt_d   = '0;
                    hold_d  = '0;
                    turn_d  = TW'(1);
                    // Only a pure hold-limit revocation counts as a timeout;
                    // a coincident done or dropped request is a normal release.
                    tout_d  = hold_hit && !own_done && own_req;
                end else begin
                    hold_d  = hold_q + HW'(1);
                end
            end

            S_TURN: begin
                // Drivers stay off for exactly TURN cycles before the next owner.
                if (turn_q == TURN_LIM) begin
                    turn_d = '0;
                    if (win_vld) begin
                        state_d = S_DRIVE;
                        gnt_d   = onehot(win_idx);
                        owner_d = win_idx;
                        ptr_d   = win_idx;
                        hold_d  = HW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                hold_d  = '0;
                turn_d  = '0;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately, mid-grant included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= LAST_ID;
            hold_q  <= '0;
            turn_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            tout_q  <= tout_d;
        end
    end

    assign gnt      = gnt_q;
    assign drv_en   = gnt_q;
    assign bus_busy = |gnt_q;
    assign owner_id = owner_q;
    assign timeout  = tout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter with a per-cycle invariant monitor.
module tb_tristate_bus_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 8;
    localparam int BOUND = (N - 1) * (HOLD + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] req_a, done_a, gnt_a, drv_a;
    logic       busy_a, tout_a;
    logic [1:0] own_a;

    logic [3:0] req_b, done_b, gnt_b, drv_b;
    logic       busy_b, tout_b;
    logic [1:0] own_b;

    int checks   = 0;
    int failures = 0;

    tristate_bus_arbiter #(.N(4), .HOLD_MAX(8), .TURN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
        .gnt(gnt_a), .drv_en(drv_a), .bus_busy(busy_a),
        .owner_id(own_a), .timeout(tout_a)
    );

    tristate_bus_arbiter #(.N(4), .HOLD_MAX(8), .TURN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
        .gnt(gnt_b), .drv_en(drv_b), .bus_busy(busy_b),
        .owner_id(own_b), .timeout(tout_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a  = '0;
        done_a = '0;
        req_b  = '0;
        done_b = '0;
        rst_n  = 1'b0;
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
    endtask

    // Invariant monitor sampled on the falling edge.
    initial begin
        int         wait_a[4];
        logic [3:0] prev_a;
        logic [3:0] prev_b;
        prev_a = '0;
        prev_b = '0;
        foreach (wait_a[i]) wait_a[i] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_a = '0;
                prev_b = '0;
                foreach (wait_a[i]) wait_a[i] = 0;
            end else begin
                chk("onehot_a", 32'($countones(drv_a) <= 1), 32'd1);
                chk("onehot_b", 32'($countones(drv_b) <= 1), 32'd1);
                chk("handoff_a", 32'(prev_a != 0 && drv_a != 0 && drv_a != prev_a), 32'd0);
                chk("handoff_b", 32'(prev_b != 0 && drv_b != 0 && drv_b != prev_b), 32'd0);
                chk("busy_a", 32'(busy_a), 32'(drv_a != 0));
                chk("drv_eq_gnt_a", 32'(drv_a), 32'(gnt_a));
                for (int i = 0; i < 4; i++) begin
                    if (req_a[i] && !gnt_a[i]) wait_a[i]++;
                    else wait_a[i] = 0;
                    chk("starve_a", 32'(wait_a[i] > BOUND), 32'd0);
                end
                prev_a = drv_a;
                prev_b = drv_b;
            end
        end
    end

    initial begin
        logic [3:0] exp_g;
        req_a  = '0;
        done_a = '0;
        req_b  = '0;
        done_b = '0;

        // Reset values
        repeat (2) tick();
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_drv", 32'(drv_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_owner", 32'(own_a), 32'd0);
        chk("rst_tout", 32'(tout_a), 32'd0);

        // Asynchronous reset in the 3rd DRIVE cycle
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        chk("arst_g1", 32'(gnt_a), 32'h1);
        tick();
        tick();
        chk("arst_drv3", 32'(gnt_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt_now", 32'(gnt_a), 32'd0);
        chk("arst_drv_now", 32'(drv_a), 32'd0);
        chk("arst_busy_now", 32'(busy_a), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_regrant", 32'(gnt_a), 32'h1);
        chk("arst_owner", 32'(own_a), 32'd0);

        // Single requester released by done with req dropped on the same cycle
        do_reset();
        req_a = 4'b0100;
        tick();
        chk("single_d1", 32'(gnt_a), 32'h4);
        chk("single_own", 32'(own_a), 32'd2);
        tick();
        chk("single_d2", 32'(gnt_a), 32'h4);
        tick();
        chk("single_d3", 32'(gnt_a), 32'h4);
        done_a = 4'b0100;
        req_a  = 4'b0000;
        tick();
        chk("single_rel", 32'(gnt_a), 32'd0);
        chk("single_tout", 32'(tout_a), 32'd0);
        chk("single_own_hold", 32'(own_a), 32'd2);
        done_a = '0;
        tick();
        chk("single_idle", 32'(gnt_a), 32'd0);
        chk("single_tout2", 32'(tout_a), 32'd0);
        chk("single_own_idle", 32'(own_a), 32'd2);

        // Full contention: rotation, 8-cycle grants, 1-cycle gaps, timeout pulse
        do_reset();
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 8; c++) begin
                tick();
                chk("full_gnt", 32'(gnt_a), 32'(exp_g));
                chk("full_tout_drive", 32'(tout_a), 32'd0);
            end
            chk("full_owner", 32'(own_a), 32'(g % 4));
            if (g < 4) begin
                tick();
                chk("full_gap", 32'(gnt_a), 32'd0);
                chk("full_tout", 32'(tout_a), 32'd1);
            end
        end

        // done coinciding with the hold limit, then req dropped mid-grant
        do_reset();
        req_a = 4'b0001;
        repeat (8) tick();
        chk("simul_d8", 32'(gnt_a), 32'h1);
        done_a = 4'b0001;
        tick();
        chk("simul_rel", 32'(gnt_a), 32'd0);
        chk("simul_tout", 32'(tout_a), 32'd0);
        done_a = '0;
        tick();
        chk("simul_regrant", 32'(gnt_a), 32'h1);
        repeat (4) tick();
        chk("drop_d5", 32'(gnt_a), 32'h1);
        req_a = '0;
        tick();
        chk("drop_rel", 32'(gnt_a), 32'd0);
        chk("drop_tout", 32'(tout_a), 32'd0);

        // TURN=3 alternation between two requesters
        do_reset();
        req_b = 4'b0011;
        for (int g = 0; g < 3; g++) begin
            exp_g = 4'b0001 << (g % 2);
            for (int c = 0; c < 8; c++) begin
                tick();
                chk("turn3_gnt", 32'(gnt_b), 32'(exp_g));
            end
            if (g < 2) begin
                for (int t = 0; t < 3; t++) begin
                    tick();
                    chk("turn3_gap", 32'(drv_b), 32'd0);
                    if (t == 0) chk("turn3_tout", 32'(tout_b), 32'd1);
                end
            end
        end

        // Randomized req/done under the invariant monitor
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(15) == 0) req_a[i] = ~req_a[i];
                done_a[i] = ($urandom_range(7) == 0);
            end
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
